// File: rtl/coherence_bus_arb_pkg.sv
// Shared types and default sizing for the coherence bus arbiter.
package coherence_bus_arb_pkg;

    localparam int DEF_CPUS             = 4;
    localparam int DEF_BLOCK_SIZE_WORDS = 2;
    localparam int DEF_TIMEOUT          = 20;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        GRANT = 3'd1,
        XFER  = 3'd2,
        DONE  = 3'd3,
        ERR   = 3'd4
    } arb_state_t;

    // Width of an index into n items; a single item still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first set request at or after ptr,
// searching upward with wrap. Built as rotate, find-first, un-rotate so the
// same block can serve the snoop-response path.
module rr_priority_picker
    import coherence_bus_arb_pkg::*;
#(
    parameter int CPUS = DEF_CPUS,
    parameter int IDW  = idx_width(CPUS)
) (
    input  logic [CPUS-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic            found,
    output logic [IDW-1:0]  idx
);

    logic [CPUS-1:0] rot;
    logic [IDW-1:0]  first;

    // (a + b) mod CPUS for operands already below CPUS.
    function automatic logic [IDW-1:0] add_mod(input logic [IDW-1:0] a,
                                               input logic [IDW-1:0] b);
        logic [IDW:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum >= (IDW+1)'(CPUS)) begin
            sum = sum - (IDW+1)'(CPUS);
        end
        return sum[IDW-1:0];
    endfunction

    // Rotate so that the request at ptr lands in bit 0.
    genvar gi;
    generate
        for (gi = 0; gi < CPUS; gi++) begin : g_rot
            assign rot[gi] = req[add_mod(IDW'(gi), ptr)];
        end
    endgenerate

    // Lowest set bit of the rotated vector, then map back to a cache index.
    always_comb begin
        found = 1'b0;
        first = '0;
        for (int i = CPUS - 1; i >= 0; i--) begin
            if (rot[i]) begin
                found = 1'b1;
                first = IDW'(i);
            end
        end
        idx = add_mod(first, ptr);
    end

endmodule

// File: rtl/coherence_bus_arbiter.sv
// Round-robin owner selection and block-transfer sequencing for the shared
// coherence bus. One owner at a time; the bus is released on the last L2
// word acknowledgement or when the inter-beat watchdog expires.
module coherence_bus_arbiter
    import coherence_bus_arb_pkg::*;
#(
    parameter int   CPUS             = DEF_CPUS,
    parameter int   BLOCK_SIZE_WORDS = DEF_BLOCK_SIZE_WORDS,
    parameter int   TIMEOUT          = DEF_TIMEOUT,
    localparam int  IDW              = idx_width(CPUS),
    localparam int  WW               = idx_width(BLOCK_SIZE_WORDS)
) (
    input  logic            CLK,
    input  logic            nRST,
    input  logic [CPUS-1:0] req,
    output logic [CPUS-1:0] grant,
    output logic [IDW-1:0]  owner,
    output logic            bus_start,
    input  logic            l2_ack,
    output logic [WW-1:0]   word_idx,
    output logic            xfer_done,
    output logic            timeout_err
);

    localparam int             WDW       = idx_width(TIMEOUT);
    localparam logic [WW-1:0]  LAST_WORD = WW'(BLOCK_SIZE_WORDS - 1);
    localparam logic [WDW-1:0] WDOG_LAST = WDW'(TIMEOUT - 1);
    localparam logic [IDW-1:0] LAST_CPU  = IDW'(CPUS - 1);

    arb_state_t      state_reg, state_next;
    logic [IDW-1:0]  owner_reg, owner_next;
    logic [IDW-1:0]  rr_ptr_reg, rr_ptr_next;
    logic [CPUS-1:0] grant_reg, grant_next;
    logic [WW-1:0]   word_cnt_reg, word_cnt_next;
    logic [WDW-1:0]  wdog_reg, wdog_next;
    logic            pick_found;
    logic [IDW-1:0]  pick_idx;

    rr_priority_picker #(
        .CPUS (CPUS),
        .IDW  (IDW)
    ) u_picker (
        .req   (req),
        .ptr   (rr_ptr_reg),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // State and datapath registers; reset clears everything at once.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_reg    <= IDLE;
            owner_reg    <= '0;
            rr_ptr_reg   <= '0;
            grant_reg    <= '0;
            word_cnt_reg <= '0;
            wdog_reg     <= '0;
        end else begin
            state_reg    <= state_next;
            owner_reg    <= owner_next;
            rr_ptr_reg   <= rr_ptr_next;
            grant_reg    <= grant_next;
            word_cnt_reg <= word_cnt_next;
            wdog_reg     <= wdog_next;
        end
    end

    // Next-state logic: arbitrate in IDLE, count beats and watchdog in XFER.
    always_comb begin
        state_next    = state_reg;
        owner_next    = owner_reg;
        rr_ptr_next   = rr_ptr_reg;
        grant_next    = grant_reg;
        word_cnt_next = word_cnt_reg;
        wdog_next     = wdog_reg;

        case (state_reg)
            IDLE: begin
                if (pick_found) begin
                    owner_next           = pick_idx;
                    grant_next           = '0;
                    grant_next[pick_idx] = 1'b1;
                    state_next           = GRANT;
                end
            end
            GRANT: begin
                word_cnt_next = '0;
                wdog_next     = '0;
                state_next    = XFER;
            end
            XFER: begin
                // An ack in the expiry cycle is a normal beat, so it is tested first.
                if (l2_ack) begin
                    wdog_next = '0;
                    if (word_cnt_reg == LAST_WORD) begin
                        word_cnt_next = '0;
                        state_next    = DONE;
                    end else begin
                        word_cnt_next = word_cnt_reg + WW'(1);
                    end
                end else if (wdog_reg == WDOG_LAST) begin
                    wdog_next     = '0;
                    word_cnt_next = '0;
                    state_next    = ERR;
                end else begin
                    wdog_next = wdog_reg + WDW'(1);
                end
            end
            DONE, ERR: begin
                // Start the next search just past the finishing owner.
                rr_ptr_next = (owner_reg == LAST_CPU) ? '0 : owner_reg + IDW'(1);
                grant_next  = '0;
                state_next  = IDLE;
            end
            default: begin
                grant_next = '0;
                state_next = IDLE;
            end
        endcase
    end

    assign grant       = grant_reg;
    assign owner       = owner_reg;
    assign word_idx    = word_cnt_reg;
    assign bus_start   = (state_reg == GRANT);
    assign xfer_done   = (state_reg == DONE);
    assign timeout_err = (state_reg == ERR);

endmodule

// File: tb/tb_coherence_bus_arbiter.sv
// Directed bench for coherence_bus_arbiter: expected grants and completion
// kinds are queued as requests are raised and checked when the DUT acts.
module tb_coherence_bus_arbiter;

    localparam int CPUS = 4;
    localparam int BSW  = 2;
    localparam int TMO  = 20;

    logic            CLK;
    logic            nRST;
    logic [CPUS-1:0] req;
    logic [CPUS-1:0] grant;
    logic [1:0]      owner;
    logic            bus_start;
    logic            l2_ack;
    logic [0:0]      word_idx;
    logic            xfer_done;
    logic            timeout_err;

    typedef struct {
        int owner;
        bit err;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   fails  = 0;

    coherence_bus_arbiter #(
        .CPUS             (CPUS),
        .BLOCK_SIZE_WORDS (BSW),
        .TIMEOUT          (TMO)
    ) dut (
        .CLK         (CLK),
        .nRST        (nRST),
        .req         (req),
        .grant       (grant),
        .owner       (owner),
        .bus_start   (bus_start),
        .l2_ack      (l2_ack),
        .word_idx    (word_idx),
        .xfer_done   (xfer_done),
        .timeout_err (timeout_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: compare each grant and each completion with the queue.
    always @(negedge CLK) begin
        if (nRST) begin
            if (bus_start) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_grant", {31'b0, bus_start}, 32'd0);
                end else begin
                    $display("grant   owner=%0d grant=%b", owner, grant);
                    chk("grant_owner", 32'(owner), exp_q[0].owner);
                    chk("grant_onehot", 32'(grant), 32'(1) << exp_q[0].owner);
                end
            end
            if (xfer_done || timeout_err) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_end", {31'b0, xfer_done | timeout_err}, 32'd0);
                end else begin
                    exp_t ex;
                    ex = exp_q.pop_front();
                    $display("end     owner=%0d done=%b timeout=%b", owner, xfer_done, timeout_err);
                    chk("end_kind", {30'b0, xfer_done, timeout_err}, ex.err ? 32'd1 : 32'd2);
                    chk("end_grant_held", 32'(grant), 32'(1) << ex.owner);
                end
            end
        end
    end

    task automatic wait_start();
        int cnt;
        cnt = 0;
        while (1) begin
            @(negedge CLK);
            cnt++;
            if (bus_start) break;
            if (cnt >= 60) begin
                chk("wait_start_bound", {31'b0, bus_start}, 32'd1);
                break;
            end
        end
    endtask

    task automatic wait_end(output int cnt);
        cnt = 0;
        while (1) begin
            @(negedge CLK);
            cnt++;
            if (xfer_done || timeout_err) break;
            if (cnt >= 100) begin
                chk("wait_end_bound", {31'b0, xfer_done | timeout_err}, 32'd1);
                break;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int cnt;
        int errs;

        // Reset with every cache requesting.
        nRST   = 1'b1;
        req    = 4'b1111;
        l2_ack = 1'b1;
        #1 nRST = 1'b0;
        #1;
        chk("reset_grant", 32'(grant), 0);
        chk("reset_owner", 32'(owner), 0);
        chk("reset_start", {31'b0, bus_start}, 0);
        chk("reset_done", {31'b0, xfer_done}, 0);
        chk("reset_timeout", {31'b0, timeout_err}, 0);
        chk("reset_word", 32'(word_idx), 0);
        repeat (2) @(negedge CLK);
        nRST = 1'b1;

        // All requesting: order 0,1,2,3,0 with one idle cycle between grants.
        for (int n = 0; n < 5; n++) exp_q.push_back('{owner: n % CPUS, err: 1'b0});
        wait_start();
        for (int n = 0; n < 5; n++) begin
            wait_end(cnt);
            chk("rr_xfer_len", cnt, BSW + 1);
            if (n == 4) req = '0;
            @(negedge CLK);
            chk("rr_idle_grant", 32'(grant), 0);
            chk("rr_idle_start", {31'b0, bus_start}, 0);
            if (n < 4) begin
                @(negedge CLK);
                chk("rr_regrant", {31'b0, bus_start}, 1);
            end
        end

        // Single requester CPU 2 with an ack every cycle.
        req = 4'b0100;
        exp_q.push_back('{owner: 2, err: 1'b0});
        @(negedge CLK);
        chk("single_grant", 32'(grant), 32'b0100);
        chk("single_owner", 32'(owner), 2);
        chk("single_start", {31'b0, bus_start}, 1);
        @(negedge CLK);
        chk("single_start_pulse", {31'b0, bus_start}, 0);
        wait_end(cnt);
        chk("single_done_delay", cnt + 1, 3);
        chk("single_done", {31'b0, xfer_done}, 1);
        req = '0;
        @(negedge CLK);
        chk("single_release", 32'(grant), 0);
        chk("single_done_pulse", {31'b0, xfer_done}, 0);

        // Pointer now at 3: CPU 3 wins over CPU 0, then CPU 0.
        req = 4'b1001;
        exp_q.push_back('{owner: 3, err: 1'b0});
        exp_q.push_back('{owner: 0, err: 1'b0});
        for (int n = 0; n < 2; n++) begin
            wait_start();
            wait_end(cnt);
            req[owner] = 1'b0;
        end

        // Stalled L2 on CPU 1; CPU 3 raises req mid-transfer.
        l2_ack = 1'b0;
        req    = 4'b0010;
        exp_q.push_back('{owner: 1, err: 1'b1});
        exp_q.push_back('{owner: 3, err: 1'b0});
        wait_start();
        req[3] = 1'b1;
        wait_end(cnt);
        chk("stall_timeout_delay", cnt, TMO + 1);
        chk("stall_timeout", {31'b0, timeout_err}, 1);
        chk("stall_no_done", {31'b0, xfer_done}, 0);
        @(negedge CLK);
        chk("stall_idle_grant", 32'(grant), 0);

        // Late acks on CPU 3, each landing in the wdog==TIMEOUT-1 cycle.
        wait_start();
        errs = 0;
        for (int j = 1; j <= 2 * TMO; j++) begin
            @(negedge CLK);
            if (timeout_err) errs++;
            if (j == TMO) chk("late_word0", 32'(word_idx), 0);
            if (j == TMO + 1) chk("late_word1", 32'(word_idx), 1);
            l2_ack = (j == TMO) || (j == 2 * TMO);
        end
        @(negedge CLK);
        if (timeout_err) errs++;
        chk("late_done", {31'b0, xfer_done}, 1);
        chk("late_no_timeout", errs, 0);
        req[3] = 1'b0;
        l2_ack = 1'b1;

        // CPU 1 still requesting: reset it after the first ack.
        exp_q.push_back('{owner: 1, err: 1'b0});
        wait_start();
        @(negedge CLK);
        @(negedge CLK);
        chk("rst_pre_word", 32'(word_idx), 1);
        #1 nRST = 1'b0;
        #1;
        chk("rst_async_grant", 32'(grant), 0);
        chk("rst_async_owner", 32'(owner), 0);
        chk("rst_async_word", 32'(word_idx), 0);
        chk("rst_async_start", {31'b0, bus_start}, 0);
        chk("rst_async_done", {31'b0, xfer_done}, 0);
        chk("rst_async_timeout", {31'b0, timeout_err}, 0);
        exp_q.delete();
        req = 4'b0001;
        repeat (2) @(negedge CLK);
        chk("rst_hold_done", {31'b0, xfer_done}, 0);
        nRST = 1'b1;

        // CPU 0 after reset, dropping req at word 0.
        exp_q.push_back('{owner: 0, err: 1'b0});
        wait_start();
        chk("rst_first_owner", 32'(owner), 0);
        @(negedge CLK);
        chk("drop_word0", 32'(word_idx), 0);
        req = '0;
        @(negedge CLK);
        chk("drop_word1", 32'(word_idx), 1);
        chk("drop_grant_kept", 32'(grant), 32'b0001);
        @(negedge CLK);
        chk("drop_done", {31'b0, xfer_done}, 1);
        chk("drop_done_word", 32'(word_idx), 0);
        @(negedge CLK);
        chk("drop_idle_grant", 32'(grant), 0);
        chk("drop_idle_word", 32'(word_idx), 0);

        repeat (5) @(negedge CLK);
        chk("queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
